// File: rtl/contact_pkg.sv
// Shared types and helpers for the prime-pulse beacon generator.
package contact_pkg;

  // Largest sequence the prime table supports; the 32nd prime (131) fits in 8 bits.
  localparam int MAX_PRIMES = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_PRIME_GAP,
    ST_SEQ_GAP
  } contact_state_t;

  // Returns the idx-th prime (idx 0 -> 2) by trial division; evaluated only at
  // elaboration, so the loop cost never reaches hardware.
  function automatic logic [7:0] get_prime(input int idx);
    int          found;
    logic [7:0]  result;
    bit          is_p;
    found  = 0;
    result = 8'd0;
    for (int n = 2; (n <= 131) && (found <= idx); n++) begin
      is_p = 1'b1;
      for (int d = 2; d * d <= n; d++) begin
        if (n % d == 0) is_p = 1'b0;
      end
      if (is_p) begin
        if (found == idx) result = 8'(n);
        found++;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/contact_prime_rom.sv
// Combinational prime lookup: prime_o = prime(idx_i), table fixed at elaboration.
module contact_prime_rom #(
  parameter int NUM_PRIMES = 8
) (
  input  logic [4:0] idx_i,
  output logic [7:0] prime_o
);
  import contact_pkg::*;

  // Full 32-entry table so the 5-bit index never runs off the end; entries
  // past NUM_PRIMES read as zero and are never selected by the sequencer.
  logic [7:0] rom_tbl [MAX_PRIMES];

  for (genvar g = 0; g < MAX_PRIMES; g++) begin : g_rom
    if (g < NUM_PRIMES) begin : g_used
      localparam logic [7:0] PRIME_VAL = get_prime(g);
      assign rom_tbl[g] = PRIME_VAL;
    end else begin : g_pad
      assign rom_tbl[g] = 8'd0;
    end
  end

  assign prime_o = rom_tbl[idx_i];

endmodule

// File: rtl/contact_multi.sv
// Prime-pulse beacon: emits prime(0) pulses, a gap, prime(1) pulses, ... then a
// sequence gap, in free-run or one-shot mode, with busy/done handshake.
module contact_multi
  import contact_pkg::*;
#(
  parameter int          NUM_PRIMES         = 8,
  parameter logic [31:0] PULSE_LEN_COUNT    = 32'd8,
  parameter logic [31:0] PULSE_GAP_COUNT    = 32'd8,
  parameter logic [31:0] INTER_PRIME_GAP    = 32'd32,
  parameter logic [31:0] INTER_SEQUENCE_GAP = 32'd128,
  parameter int          CNT_WIDTH          = 32,
  parameter logic [31:0] ILA_CONTACT_DEBUG  = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 one_shot,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 prime_seq,
  output logic [4:0]           prime_idx,
  output logic [CNT_WIDTH-1:0] prime_seq_cnt
);

  // Parameter legality, caught at elaboration rather than as odd waveforms.
  if (NUM_PRIMES < 1 || NUM_PRIMES > MAX_PRIMES) begin : g_bad_num_primes
    $fatal(1, "contact_multi: NUM_PRIMES must be in 1..32");
  end
  if (PULSE_LEN_COUNT == 32'd0 || PULSE_GAP_COUNT == 32'd0 ||
      INTER_PRIME_GAP == 32'd0 || INTER_SEQUENCE_GAP == 32'd0) begin : g_bad_timing
    $fatal(1, "contact_multi: all length/gap counts must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $fatal(1, "contact_multi: CNT_WIDTH must be >= 1");
  end

  localparam logic [4:0] LAST_IDX = 5'(NUM_PRIMES - 1);

  contact_state_t         state_q, state_d;
  logic [31:0]            timer_q, timer_d;      // cycles spent in the current state
  logic [7:0]             pulse_q, pulse_d;      // pulses already completed in this group
  logic [4:0]             prime_idx_q, prime_idx_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   done_d;
  logic                   prime_seq_q, busy_q, done_q;
  logic [7:0]             cur_prime;
  logic [7:0]             pulse_next;

  contact_prime_rom #(
    .NUM_PRIMES (NUM_PRIMES)
  ) u_prime_rom (
    .idx_i   (prime_idx_q),
    .prime_o (cur_prime)
  );

  assign pulse_next = pulse_q + 8'd1;

  // Next-state logic: each timed state exits when its timer reaches length-1.
  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 32'd1;
    pulse_d     = pulse_q;
    prime_idx_d = prime_idx_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (enable && (!one_shot || start)) begin
          state_d     = ST_PULSE_HI;
          prime_idx_d = '0;
          pulse_d     = '0;
        end
      end
      ST_PULSE_HI: begin
        if (timer_q == PULSE_LEN_COUNT - 32'd1) begin
          timer_d = '0;
          if (pulse_next < cur_prime) begin
            pulse_d = pulse_next;
            state_d = ST_PULSE_LO;
          end else if (prime_idx_q < LAST_IDX) begin
            state_d = ST_PRIME_GAP;
          end else begin
            state_d = ST_SEQ_GAP;
          end
        end
      end
      ST_PULSE_LO: begin
        if (timer_q == PULSE_GAP_COUNT - 32'd1) begin
          timer_d = '0;
          state_d = ST_PULSE_HI;
        end
      end
      ST_PRIME_GAP: begin
        if (timer_q == INTER_PRIME_GAP - 32'd1) begin
          timer_d     = '0;
          prime_idx_d = prime_idx_q + 5'd1;
          pulse_d     = '0;
          state_d     = ST_PULSE_HI;
        end
      end
      ST_SEQ_GAP: begin
        if (timer_q == INTER_SEQUENCE_GAP - 32'd1) begin
          timer_d     = '0;
          cnt_d       = cnt_q + CNT_WIDTH'(1);
          done_d      = 1'b1;
          prime_idx_d = '0;
          pulse_d     = '0;
          // one_shot is only consulted here, so a mid-sequence change waits until now.
          state_d     = (enable && !one_shot) ? ST_PULSE_HI : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Dropping enable abandons the sequence without counting it.
    if (!enable && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      timer_d     = '0;
      pulse_d     = '0;
      prime_idx_d = '0;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
    end
  end

  // State and output registers; outputs are derived from the next state so
  // prime_seq rises on the same edge that leaves IDLE.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pulse_q     <= '0;
      prime_idx_q <= '0;
      cnt_q       <= '0;
      prime_seq_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pulse_q     <= pulse_d;
      prime_idx_q <= prime_idx_d;
      cnt_q       <= cnt_d;
      prime_seq_q <= (state_d == ST_PULSE_HI);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign prime_seq     = prime_seq_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign prime_idx     = prime_idx_q;
  assign prime_seq_cnt = cnt_q;

  // Nets tagged for the ILA core inserter; no fabric logic reads them.
  if (ILA_CONTACT_DEBUG != 32'd0) begin : g_ila
    (* mark_debug = "true" *) logic [47:0] dbg_probe_unused;
    assign dbg_probe_unused = {state_q, timer_q, pulse_q, prime_idx_q};
  end

endmodule

// File: tb/tb_contact_multi.sv
// Scoreboard bench for contact_multi: three instances share one stimulus stream
// (main config, 2-bit counter, single-prime config). A waveform-playback model
// predicts every cycle; a monitor pops and compares after each clock edge.
module tb_contact_multi;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst, enable, one_shot, start;

  logic       a_seq, a_busy, a_done;
  logic [4:0] a_idx;
  logic [31:0] a_cnt;
  logic       w_seq, w_busy, w_done;
  logic [4:0] w_idx;
  logic [1:0] w_cnt;
  logic       n_seq, n_busy, n_done;
  logic [4:0] n_idx;
  logic [31:0] n_cnt;

  always #5 clk = ~clk;

  contact_multi #(
    .NUM_PRIMES(3), .PULSE_LEN_COUNT(32'd2), .PULSE_GAP_COUNT(32'd1),
    .INTER_PRIME_GAP(32'd4), .INTER_SEQUENCE_GAP(32'd8), .CNT_WIDTH(32),
    .ILA_CONTACT_DEBUG(32'd0)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .one_shot(one_shot), .start(start),
    .busy(a_busy), .done(a_done), .prime_seq(a_seq), .prime_idx(a_idx),
    .prime_seq_cnt(a_cnt)
  );

  contact_multi #(
    .NUM_PRIMES(3), .PULSE_LEN_COUNT(32'd2), .PULSE_GAP_COUNT(32'd1),
    .INTER_PRIME_GAP(32'd4), .INTER_SEQUENCE_GAP(32'd8), .CNT_WIDTH(2),
    .ILA_CONTACT_DEBUG(32'd0)
  ) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .one_shot(one_shot), .start(start),
    .busy(w_busy), .done(w_done), .prime_seq(w_seq), .prime_idx(w_idx),
    .prime_seq_cnt(w_cnt)
  );

  contact_multi #(
    .NUM_PRIMES(1), .PULSE_LEN_COUNT(32'd1), .PULSE_GAP_COUNT(32'd1),
    .INTER_PRIME_GAP(32'd4), .INTER_SEQUENCE_GAP(32'd8), .CNT_WIDTH(32),
    .ILA_CONTACT_DEBUG(32'd0)
  ) dut_n (
    .clk(clk), .rst(rst), .enable(enable), .one_shot(one_shot), .start(start),
    .busy(n_busy), .done(n_done), .prime_seq(n_seq), .prime_idx(n_idx),
    .prime_seq_cnt(n_cnt)
  );

  typedef struct packed {
    logic        seq;
    logic        busy;
    logic        done;
    logic [4:0]  idx;
    logic [31:0] cnt;
  } obs_t;
  typedef obs_t [NI-1:0] obs3_t;

  obs3_t sb_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Reference: one sequence laid out as a per-cycle waveform, replayed by position.
  bit     wave [NI][64];
  int     widx [NI][64];
  int     wlen [NI];
  int     cw   [NI];
  bit     m_act[NI];
  int     m_pos[NI];
  longint m_cnt[NI];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d < n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nth_prime(input int i);
    int n = 1;
    int c = -1;
    while (c < i) begin
      n++;
      if (is_prime(n)) c++;
    end
    return n;
  endfunction

  task automatic build(input int k, input int np, input int len, input int gap,
                       input int ipg, input int sg, input int width);
    int pos = 0;
    int p;
    for (int i = 0; i < np; i++) begin
      p = nth_prime(i);
      for (int j = 0; j < p; j++) begin
        for (int c = 0; c < len; c++) begin wave[k][pos] = 1'b1; widx[k][pos] = i; pos++; end
        if (j < p - 1)
          for (int c = 0; c < gap; c++) begin wave[k][pos] = 1'b0; widx[k][pos] = i; pos++; end
      end
      if (i < np - 1)
        for (int c = 0; c < ipg; c++) begin wave[k][pos] = 1'b0; widx[k][pos] = i; pos++; end
    end
    for (int c = 0; c < sg; c++) begin wave[k][pos] = 1'b0; widx[k][pos] = np - 1; pos++; end
    wlen[k] = pos;
    cw[k]   = width;
    m_act[k] = 1'b0;
    m_pos[k] = 0;
    m_cnt[k] = 0;
  endtask

  // Advance one instance's model across the coming clock edge.
  task automatic model_step(input int k, output obs_t o);
    bit d = 1'b0;
    if (rst) begin
      m_act[k] = 1'b0; m_pos[k] = 0; m_cnt[k] = 0;
    end else if (m_act[k]) begin
      if (!enable) begin
        m_act[k] = 1'b0; m_pos[k] = 0;
      end else if (m_pos[k] == wlen[k] - 1) begin
        m_cnt[k] = (m_cnt[k] + 1) % (longint'(1) << cw[k]);
        d = 1'b1;
        m_pos[k] = 0;
        if (one_shot) m_act[k] = 1'b0;
      end else begin
        m_pos[k] = m_pos[k] + 1;
      end
    end else if (enable && (!one_shot || start)) begin
      m_act[k] = 1'b1; m_pos[k] = 0;
    end
    o.seq  = m_act[k] ? wave[k][m_pos[k]] : 1'b0;
    o.busy = m_act[k];
    o.done = d;
    o.idx  = m_act[k] ? 5'(widx[k][m_pos[k]]) : 5'd0;
    o.cnt  = 32'(m_cnt[k]);
  endtask

  // Queue the expectation for the next edge, then return at the following negedge.
  task automatic tick();
    obs3_t e;
    obs_t  o;
    for (int k = 0; k < NI; k++) begin
      model_step(k, o);
      e[k] = o;
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  obs3_t mon_e, mon_a;

  // Monitor: compares every instance just after each clock edge that has an expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        mon_a[0] = {a_seq, a_busy, a_done, a_idx, a_cnt};
        mon_a[1] = {w_seq, w_busy, w_done, w_idx, 30'd0, w_cnt};
        mon_a[2] = {n_seq, n_busy, n_done, n_idx, n_cnt};
        for (int k = 0; k < NI; k++)
          check($sformatf("cycle_dut%0d", k), 64'(mon_a[k]), 64'(mon_e[k]));
      end
    end
  end

  int n;
  int target;

  initial begin
    build(0, 3, 2, 1, 4, 8, 32);
    build(1, 3, 2, 1, 4, 8, 2);
    build(2, 1, 1, 1, 4, 8, 32);
    rst = 1'b1; enable = 1'b1; one_shot = 1'b0; start = 1'b1;
    @(negedge clk);

    // Reset dominates even with enable/start high.
    repeat (3) tick();
    check("reset_seq",  64'(a_seq),  64'd0);
    check("reset_busy", 64'(a_busy), 64'd0);
    check("reset_cnt",  64'(a_cnt),  64'd0);
    rst = 1'b0; enable = 1'b0; start = 1'b0;
    tick();

    // Free-run: three back-to-back 43-cycle sequences.
    enable = 1'b1; one_shot = 1'b0;
    tick();
    check("fr_first_pulse", 64'(a_seq), 64'd1);
    for (int s = 1; s <= 3; s++) begin
      n = 0;
      do begin tick(); n++; end while (!a_done && n < 200);
      check($sformatf("fr_period_%0d", s), 64'(n), 64'd43);
      check($sformatf("fr_cnt_%0d", s), 64'(a_cnt), 64'(s));
    end
    enable = 1'b0;
    repeat (2) tick();

    // One-shot: single start, second start while busy must be ignored.
    enable = 1'b1; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (a_busy && n < 200) begin
      if (n == 20) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    check("os_busy_len", 64'(n),      64'd43);
    check("os_done",     64'(a_done), 64'd1);
    check("os_cnt",      64'(a_cnt),  64'd4);
    repeat (10) tick();
    check("os_no_requeue", 64'(a_busy), 64'd0);

    // Abort while emitting the prime_idx=1 group, then restart from prime 2.
    one_shot = 1'b0;
    tick();
    target = 9 + $urandom_range(0, 7);
    n = 0;
    while (m_pos[0] != target && n < 100) begin tick(); n++; end
    check("abort_pre_idx", 64'(a_idx), 64'd1);
    enable = 1'b0;
    tick();
    check("abort_seq",  64'(a_seq),  64'd0);
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_idx",  64'(a_idx),  64'd0);
    check("abort_done", 64'(a_done), 64'd0);
    check("abort_cnt",  64'(a_cnt),  64'd4);
    enable = 1'b1;
    tick();
    check("restart_seq", 64'(a_seq), 64'd1);
    check("restart_idx", 64'(a_idx), 64'd0);

    // Reset mid-sequence once five sequences have completed.
    target = $urandom_range(1, 40);
    n = 0;
    while (!(m_cnt[0] == 5 && m_pos[0] == target) && n < 300) begin tick(); n++; end
    check("pre_rst_cnt", 64'(a_cnt), 64'd5);
    rst = 1'b1;
    tick();
    check("rst_seq",  64'(a_seq),  64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_idx",  64'(a_idx),  64'd0);
    check("rst_cnt",  64'(a_cnt),  64'd0);
    rst = 1'b0;

    // Random mix of enable drops, mode changes, starts and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 99) == 0) one_shot = ~one_shot;
      start  = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0; enable = 1'b0; start = 1'b0;
    repeat (3) tick();

    n = 0;
    while (sb_q.size() != 0 && n < 10) begin @(negedge clk); n++; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
